// File: rtl/bldc_tick_scheduler.sv
// Clock-enable scheduler: pwm_tick every pwm_div cycles, comm_tick every comm_div pwm_ticks,
// with deferred divisor updates in RUN. Define BLDC_TICK_CNT_EN to add the comm_count output.
module bldc_tick_scheduler #(
  parameter int DIV_W        = 8,
  parameter int PWM_DIV_RST  = 8,
  parameter int COMM_DIV_RST = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             pwm_tick,
  output logic             comm_tick,
  output logic [1:0]       state
`ifdef BLDC_TICK_CNT_EN
  ,
  output logic [15:0]      comm_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } state_t;

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] PWM_INIT = DIV_W'(PWM_DIV_RST);
  localparam logic [DIV_W-1:0] COMM_INIT = DIV_W'(COMM_DIV_RST);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] pwm_div_q, pwm_div_d;
  logic [DIV_W-1:0] comm_div_q, comm_div_d;
  logic [DIV_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0] comm_cnt_q, comm_cnt_d;
  logic             shadow_sel_q, shadow_sel_d;
  logic [DIV_W-1:0] shadow_div_q, shadow_div_d;
  logic             pwm_tick_q, pwm_tick_d;
  logic             comm_tick_q, comm_tick_d;

  logic             cfg_fire;
  logic [DIV_W-1:0] cfg_div_clamped;
  logic             pwm_wrap;
  logic             comm_wrap;
  logic             wr_en;
  logic             wr_sel;
  logic [DIV_W-1:0] wr_div;

  assign cfg_ready       = (state_q != ST_PEND);
  assign cfg_fire        = cfg_valid && cfg_ready;
  assign cfg_div_clamped = (cfg_div == '0) ? ONE : cfg_div;

  // Wraps compare against div-1, so a divisor of 1 wraps on every counting edge.
  assign pwm_wrap  = (state_q != ST_IDLE) && (pwm_cnt_q == pwm_div_q - ONE);
  assign comm_wrap = pwm_wrap && (comm_cnt_q == comm_div_q - ONE);

  always_comb begin
    // NOTE: every target gets a default first so no path through the block infers a latch.
    state_d      = state_q;
    pwm_div_d    = pwm_div_q;
    comm_div_d   = comm_div_q;
    pwm_cnt_d    = pwm_cnt_q;
    comm_cnt_d   = comm_cnt_q;
    shadow_sel_d = shadow_sel_q;
    shadow_div_d = shadow_div_q;
    pwm_tick_d   = 1'b0;
    comm_tick_d  = 1'b0;
    wr_en        = 1'b0;
    wr_sel       = 1'b0;
    wr_div       = ONE;

    unique case (state_q)
      ST_IDLE: begin
        pwm_cnt_d  = '0;
        comm_cnt_d = '0;
        if (cfg_fire) begin
          wr_en  = 1'b1;
          wr_sel = cfg_sel;
          wr_div = cfg_div_clamped;
        end
        if (enable) state_d = ST_RUN;
      end

      ST_RUN, ST_PEND: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          pwm_cnt_d  = '0;
          comm_cnt_d = '0;
          // Leaving for IDLE: nothing may be lost, so pending or same-edge writes land now.
          if (state_q == ST_PEND) begin
            wr_en  = 1'b1;
            wr_sel = shadow_sel_q;
            wr_div = shadow_div_q;
          end else if (cfg_fire) begin
            wr_en  = 1'b1;
            wr_sel = cfg_sel;
            wr_div = cfg_div_clamped;
          end
        end else begin
          pwm_cnt_d   = pwm_wrap ? '0 : pwm_cnt_q + ONE;
          if (pwm_wrap) comm_cnt_d = comm_wrap ? '0 : comm_cnt_q + ONE;
          pwm_tick_d  = pwm_wrap;
          comm_tick_d = comm_wrap;

          if (state_q == ST_RUN) begin
            if (cfg_fire) begin
              shadow_sel_d = cfg_sel;
              shadow_div_d = cfg_div_clamped;
              state_d      = ST_PEND;
            end
          end else if (shadow_sel_q ? comm_wrap : pwm_wrap) begin
            // The period ending on this edge used the old divisor; the next one uses the new.
            wr_en   = 1'b1;
            wr_sel  = shadow_sel_q;
            wr_div  = shadow_div_q;
            state_d = ST_RUN;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      if (wr_sel) comm_div_d = wr_div;
      else        pwm_div_d  = wr_div;
    end
  end

  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pwm_div_q    <= PWM_INIT;
      comm_div_q   <= COMM_INIT;
      pwm_cnt_q    <= '0;
      comm_cnt_q   <= '0;
      shadow_sel_q <= 1'b0;
      shadow_div_q <= '0;
      pwm_tick_q   <= 1'b0;
      comm_tick_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwm_div_q    <= pwm_div_d;
      comm_div_q   <= comm_div_d;
      pwm_cnt_q    <= pwm_cnt_d;
      comm_cnt_q   <= comm_cnt_d;
      shadow_sel_q <= shadow_sel_d;
      shadow_div_q <= shadow_div_d;
      pwm_tick_q   <= pwm_tick_d;
      comm_tick_q  <= comm_tick_d;
    end
  end

  assign pwm_tick  = pwm_tick_q;
  assign comm_tick = comm_tick_q;
  assign state     = state_q;

`ifdef BLDC_TICK_CNT_EN
  logic [15:0] comm_count_q, comm_count_d;

  // Counts comm_tick pulses since RUN entry; wraps naturally at 16 bits.
  always_comb begin
    comm_count_d = comm_count_q;
    if (state_q != ST_IDLE && state_d == ST_IDLE) comm_count_d = '0;
    else if (comm_tick_d)                         comm_count_d = comm_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) comm_count_q <= '0;
    else      comm_count_q <= comm_count_d;
  end

  assign comm_count = comm_count_q;
`endif

endmodule

// File: tb/tb_bldc_tick_scheduler.sv
// Self-checking bench for bldc_tick_scheduler: deadline-based reference model, directed
// scenarios and randomized enable/config traffic; checks outputs every cycle.
module tb_bldc_tick_scheduler;

  localparam int DIV_W = 8;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_sel;
  logic [DIV_W-1:0] cfg_div;
  logic             pwm_tick;
  logic             comm_tick;
  logic [1:0]       state;
`ifdef BLDC_TICK_CNT_EN
  logic [15:0]      comm_count;
`endif

  bldc_tick_scheduler #(
    .DIV_W       (DIV_W),
    .PWM_DIV_RST (8),
    .COMM_DIV_RST(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .pwm_tick  (pwm_tick),
    .comm_tick (comm_tick),
    .state     (state)
`ifdef BLDC_TICK_CNT_EN
    ,
    .comm_count(comm_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: tracks the absolute edge of the next PWM wrap and how many
  // PWM wraps remain until the next commutation wrap.
  typedef enum {M_IDLE, M_RUN, M_PEND} mmode_t;

  mmode_t m_mode;
  int     m_pwm_div, m_comm_div;
  int     m_pend_sel, m_pend_div;
  longint m_edge, m_next_wrap;
  int     m_comm_left;
  bit     m_pwm, m_comm;
  int     m_count;

  function automatic int clamp(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [1:0] mode_code(input mmode_t m);
    case (m)
      M_RUN:   return 2'b01;
      M_PEND:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_pwm_div   = 8;
    m_comm_div  = 16;
    m_pend_sel  = 0;
    m_pend_div  = 0;
    m_next_wrap = 0;
    m_comm_left = 0;
    m_pwm       = 1'b0;
    m_comm      = 1'b0;
    m_count     = 0;
  endtask

  task automatic model_write(input int sel, input int div);
    if (sel != 0) m_comm_div = div;
    else          m_pwm_div  = div;
  endtask

  task automatic model_edge();
    bit fire, was_pend, wrap, cwrap;
    m_edge++;
    fire = cfg_valid && (m_mode != M_PEND);
    if (m_mode == M_IDLE) begin
      m_pwm  = 1'b0;
      m_comm = 1'b0;
      if (fire) model_write(int'(cfg_sel), clamp(int'(cfg_div)));
      if (enable) begin
        m_mode      = M_RUN;
        m_next_wrap = m_edge + m_pwm_div;
        m_comm_left = m_comm_div;
      end
    end else if (!enable) begin
      if (m_mode == M_PEND)  model_write(m_pend_sel, m_pend_div);
      else if (fire)         model_write(int'(cfg_sel), clamp(int'(cfg_div)));
      m_mode  = M_IDLE;
      m_pwm   = 1'b0;
      m_comm  = 1'b0;
      m_count = 0;
    end else begin
      was_pend = (m_mode == M_PEND);
      wrap     = (m_edge == m_next_wrap);
      cwrap    = 1'b0;
      if (wrap) begin
        m_comm_left--;
        cwrap = (m_comm_left == 0);
      end
      m_pwm  = wrap;
      m_comm = cwrap;
      if (cwrap) m_count = (m_count + 1) & 16'hFFFF;
      if (wrap) begin
        if (was_pend && m_pend_sel == 0) begin
          m_pwm_div = m_pend_div;
          m_mode    = M_RUN;
        end
        m_next_wrap = m_edge + m_pwm_div;
      end
      if (cwrap) begin
        if (was_pend && m_pend_sel == 1) begin
          m_comm_div = m_pend_div;
          m_mode     = M_RUN;
        end
        m_comm_left = m_comm_div;
      end
      if (!was_pend && fire) begin
        m_pend_sel = int'(cfg_sel);
        m_pend_div = clamp(int'(cfg_div));
        m_mode     = M_PEND;
      end
    end
  endtask

  task automatic compare_all();
    check("pwm_tick",  32'(pwm_tick),  32'(m_pwm));
    check("comm_tick", 32'(comm_tick), 32'(m_comm));
    check("state",     32'(state),     32'(mode_code(m_mode)));
    check("cfg_ready", 32'(cfg_ready), 32'(m_mode != M_PEND));
`ifdef BLDC_TICK_CNT_EN
    check("comm_count", 32'(comm_count), 32'(m_count));
`endif
  endtask

  // One clock: model advances with the edge, DUT outputs are sampled at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cfg_write(input logic sel, input logic [DIV_W-1:0] div);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_div   = div;
    cycle();
    cfg_valid = 1'b0;
  endtask

  int pwm_seen, comm_seen;

  initial begin
    m_edge    = 0;
    rst       = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_sel   = 1'b0;
    cfg_div   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Defaults: pwm every 8 cycles, comm every 128 cycles.
    enable    = 1'b1;
    pwm_seen  = 0;
    comm_seen = 0;
    repeat (300) begin
      cycle();
      pwm_seen  += int'(pwm_tick);
      comm_seen += int'(comm_tick);
      if (comm_tick) check("comm_with_pwm", 32'(pwm_tick), 32'd1);
    end
    check("pwm_count_300", 32'(pwm_seen), 32'd37);
    check("comm_count_300", 32'(comm_seen), 32'd2);

    // IDLE write of pwm_div=3, then divisor 0 clamped to 1 while running.
    enable = 1'b0;
    cycle();
    cfg_write(1'b0, 8'd3);
    enable = 1'b1;
    repeat (20) cycle();
    cfg_write(1'b0, 8'd0);
    repeat (20) cycle();

    // Deferred pwm update: written when pwm_cnt==2 with pwm_div=8.
    enable = 1'b0;
    cycle();
    cfg_write(1'b0, 8'd8);
    enable = 1'b1;
    repeat (3) cycle();
    cfg_write(1'b0, 8'd4);
    check("pend_state", 32'(state), 32'd2);
    check("pend_ready", 32'(cfg_ready), 32'd0);
    repeat (30) cycle();

    // Pending comm update flushed by dropping enable.
    cfg_write(1'b1, 8'd2);
    repeat (5) cycle();
    enable = 1'b0;
    cycle();
    check("drop_idle", 32'(state), 32'd0);
    enable = 1'b1;
    repeat (60) cycle();

    // Randomized enable and configuration traffic.
    repeat (4000) begin
      enable    = ($urandom_range(99) < 97);
      cfg_valid = ($urandom_range(99) < 6);
      cfg_sel   = 1'($urandom_range(1));
      cfg_div   = DIV_W'($urandom_range(10));
      cycle();
    end
    cfg_valid = 1'b0;

    // Async reset while PEND: pending value discarded, defaults restored.
    enable = 1'b0;
    cycle();
    cfg_write(1'b0, 8'd200);
    enable = 1'b1;
    repeat (5) cycle();
    cfg_write(1'b1, 8'd9);
    repeat (3) cycle();
    check("pre_reset_pend", 32'(state), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("rst_pwm",   32'(pwm_tick),  32'd0);
    check("rst_comm",  32'(comm_tick), 32'd0);
    check("rst_state", 32'(state),     32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (140) cycle();

`ifdef BLDC_TICK_CNT_EN
    // comm_count wraps past 0xFFFF with both divisors at 1, clears on IDLE entry.
    enable = 1'b0;
    cycle();
    cfg_write(1'b0, 8'd0);
    cfg_write(1'b1, 8'd1);
    enable = 1'b1;
    repeat (65538) cycle();
    check("count_wrap", 32'(comm_count), 32'd1);
    enable = 1'b0;
    cycle();
    check("count_clear", 32'(comm_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bldc_tick_scheduler.md
# bldc_tick_scheduler

Programmable clock-enable scheduler for the BLDC controller. It produces a fast PWM tick strobe and a slower commutation tick strobe from the single system clock, so downstream logic runs on clock enables rather than on derived clocks. Divisors can be reconfigured at runtime through a valid/ready handshake. In RUN, updates are deferred to the next period boundary so no tick period is ever truncated or stretched mid-period.

## Interface
Parameters:
- DIV_W, 8, width of both divisor registers.
- PWM_DIV_RST, 8, PWM divisor loaded at reset (clock cycles per pwm_tick).
- COMM_DIV_RST, 16, commutation divisor loaded at reset (pwm_ticks per comm_tick).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  run request; level-sensitive.
- cfg_valid  input  1  configuration write request.
- cfg_ready  output  1  configuration write accepted when high together with cfg_valid.
- cfg_sel  input  1  target register: 0 = PWM divisor, 1 = COMM divisor.
- cfg_div  input  DIV_W  new divisor value.
- pwm_tick  output  1  one-cycle strobe, registered.
- comm_tick  output  1  one-cycle strobe, registered, always coincident with a pwm_tick.
- state  output  2  00 IDLE, 01 RUN, 10 PEND (RUN with update pending).

## Operation
- Reset (rst low): state IDLE, pwm_div=PWM_DIV_RST, comm_div=COMM_DIV_RST, both counters 0, pwm_tick=0, comm_tick=0, cfg_ready=1, shadow register cleared.
- Divisor value 0 is clamped to 1 when written. Divisor N means one tick every N units.
- IDLE:
  - Counters held at 0; ticks low.
  - A config handshake writes the selected divisor directly at that edge.
  - enable=1 moves the FSM to RUN.
- RUN:
  - pwm_cnt increments every cycle. When pwm_cnt == pwm_div-1, it wraps to 0 and pwm_tick is asserted for the next cycle.
  - comm_cnt increments on each pwm_cnt wrap. When comm_cnt == comm_div-1 at that wrap, it wraps to 0 and comm_tick is asserted in the same cycle as pwm_tick.
  - A config handshake stores cfg_sel/cfg_div in the shadow register and moves the FSM to PEND.
- PEND:
  - Counting continues as in RUN; cfg_ready=0.
  - The shadow value is applied at the wrap edge of the targeted counter (pwm_cnt wrap for sel 0; comm_cnt wrap for sel 1). The period ending at that edge uses the old divisor; the next period uses the new one.
  - After applying, the FSM returns to RUN.
- enable=0 in RUN or PEND: next state IDLE; counters cleared to 0; ticks forced low from the next cycle.
  - A pending shadow value is applied on that same edge and is never lost.
- cfg_ready = 1 in IDLE and RUN, 0 in PEND.
- Simultaneous handshake and wrap in RUN: the current wrap uses the old divisor; the new value waits for the following wrap.
- Reset mid-operation: immediate return to reset values. Pending updates are discarded.

## Timing
- Edge E: first edge with enable=1 in IDLE.
  - First pwm_tick is high during the cycle after edge E+pwm_div.
  - Subsequent pwm_ticks follow every pwm_div cycles; with pwm_div=1, pwm_tick stays high continuously.
- comm_tick period = pwm_div × comm_div cycles. The first comm_tick coincides with the comm_div-th pwm_tick.
- Config latency:
  - IDLE: 1 cycle.
  - RUN: up to one full period of the targeted counter.
- Arithmetic: counters are DIV_W bits and compare against div-1, so there is no overflow. Maximum period is 2^DIV_W-1 units.

## Configuration
- BLDC_TICK_CNT_EN defined:
  - Adds output comm_count[15:0], counting comm_tick pulses since the last RUN entry.
  - It increments on the edge on which comm_tick is asserted, wraps 0xFFFF→0, and clears to 0 on reset and on IDLE entry.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset defaults, enable=1 → pwm_tick every 8 cycles; comm_tick every 128 cycles, coincident with every 16th pwm_tick; state=01.
- In IDLE, write sel0 div=3, then enable → first pwm_tick 3 cycles after the enable edge, then every 3 cycles; write sel0 div=0 → tick every cycle.
- In RUN with pwm_div=8, write sel0 div=4 at cnt=2 → state=10 and cfg_ready=0 until wrap; that period still lasts 8 cycles, the next ones 4; then state=01 and cfg_ready=1.
- In RUN, write sel1 div=2, then drop enable before the comm wrap → IDLE next cycle, ticks low, comm_div reads back as 2 on re-enable (comm_tick every 2 pwm_ticks).
- Assert rst low mid-period while in PEND → outputs at reset values asynchronously; pending value discarded; divisors at defaults.
- With BLDC_TICK_CNT_EN defined, pwm_div=1 and comm_div=1 for 65537 cycles → comm_count wraps to 1; dropping enable → comm_count=0.
